// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types for the boot-time program loader. Holds the
//               loader state encodings and the state enum used by the FSM.
//               Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the
//               CHECK state.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_LOAD  = 3'd1;
   localparam logic [2:0] ENC_RUN   = 3'd2;
   localparam logic [2:0] ENC_ERROR = 3'd3;
   localparam logic [2:0] ENC_CHECK = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ENC_IDLE,
      ST_LOAD  = ENC_LOAD,
      ST_RUN   = ENC_RUN,
      ST_ERROR = ENC_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
      ,
      ST_CHECK = ENC_CHECK
`endif
   } loader_state_t;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Simple dual-port instruction RAM, WIDTH x DEPTH. One write
//               port, one registered read port. A read and write to the same
//               address on the same edge returns the old contents. Only the
//               read register is reset; the array itself is never cleared.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               we, waddr, wdata  - write port
//               raddr, rdata      - registered read port (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Non-blocking read of the array gives read-before-write on collisions.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule : imem_ram
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Streams instruction words over a
//               valid/ready interface into the instruction RAM starting at
//               load_base, then releases the core via cpu_en. The fetch
//               stage reads the same RAM through a registered port.
//               Optional macro PROG_LOADER_CHECKSUM_EN: one trailer word
//               after the program must equal the sum of the loaded words
//               mod 2^WIDTH, otherwise the loader enters ERROR.
// Ports       : clk, reset                    - clock, sync active-high reset
//               load_req, load_base, load_len - load command
//               halt                          - abort to IDLE
//               s_valid, s_data, s_ready      - instruction stream
//               fetch_adrs, fetch_data        - CPU fetch port
//               cpu_en, busy, error           - status
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2048
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_req,
   input  logic [$clog2(DEPTH)-1:0]  load_base,
   input  logic [$clog2(DEPTH):0]    load_len,
   input  logic                      halt,
   input  logic                      s_valid,
   input  logic [WIDTH-1:0]          s_data,
   output logic                      s_ready,
   input  logic [$clog2(DEPTH)-1:0]  fetch_adrs,
   output logic [WIDTH-1:0]          fetch_data,
   output logic                      cpu_en,
   output logic                      busy,
   output logic                      error
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

   loader_state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   remain_q, remain_d;
   logic          error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [WIDTH-1:0] sum_q, sum_d;
`endif

   logic len_ok;
   logic accept;
   logic ram_we;

   assign len_ok = (load_len != '0) && (load_len <= DEPTH_LEN);
   assign accept = s_valid && s_ready;
   assign ram_we = accept && (state_q == ST_LOAD);

   // Outputs decode registered state only, so s_ready never depends on s_valid.
`ifdef PROG_LOADER_CHECKSUM_EN
   assign s_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
   assign s_ready = (state_q == ST_LOAD);
`endif
   assign busy   = s_ready;
   assign cpu_en = (state_q == ST_RUN);
   assign error  = error_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         remain_q <= '0;
         error_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         remain_q <= remain_d;
         error_q  <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      remain_d = remain_q;
      error_d  = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      if (halt) begin
         // Abort wins over everything; error flag is deliberately kept.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
               if (load_req) begin
                  if (len_ok) begin
                     state_d  = ST_LOAD;
                     wr_ptr_d = load_base;
                     remain_d = load_len;
                     error_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                     sum_d    = '0;
`endif
                  end else begin
                     state_d = ST_ERROR;
                     error_d = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  // AW-bit pointer wraps DEPTH-1 -> 0 since DEPTH is 2^AW.
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  remain_d = remain_q - (AW+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_d    = sum_q + s_data;
                  if (remain_q == (AW+1)'(1)) state_d = ST_CHECK;
`else
                  if (remain_q == (AW+1)'(1)) state_d = ST_RUN;
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (accept) begin
                  if (s_data == sum_q) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_ERROR;
                     error_d = 1'b1;
                  end
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   imem_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_imem_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (s_data),
      .raddr (fetch_adrs),
      .rdata (fetch_data)
   );

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader (small DEPTH so address
//               wrap is cheap). A behavioural RAM image and checksum are
//               kept in plain arrays and compared against the fetch port.
//               Honours PROG_LOADER_CHECKSUM_EN for the trailer word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             reset;
   logic             load_req;
   logic [AW-1:0]    load_base;
   logic [AW:0]      load_len;
   logic             halt;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic [AW-1:0]    fetch_adrs;
   logic [WIDTH-1:0] fetch_data;
   logic             cpu_en;
   logic             busy;
   logic             error;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] mem_model [DEPTH];
   bit               written   [DEPTH];
   logic [WIDTH-1:0] words_q   [$];
   bit               unused_flag;

   always #5 clk = ~clk;

   prog_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .load_base  (load_base),
      .load_len   (load_len),
      .halt       (halt),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .fetch_adrs (fetch_adrs),
      .fetch_data (fetch_data),
      .cpu_en     (cpu_en),
      .busy       (busy),
      .error      (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag, input bit exp_err);
      check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      check({tag, "_cpu_en"},  64'(cpu_en),  64'd0);
      check({tag, "_busy"},    64'(busy),    64'd0);
      check({tag, "_error"},   64'(error),   64'(exp_err));
   endtask

   task automatic start_load(input int base, input int len);
      load_base = AW'(base);
      load_len  = (AW+1)'(len);
      load_req  = 1'b1;
      tick();
      load_req  = 1'b0;
   endtask

   // Holds s_valid until the DUT takes the word; bounded wait.
   task automatic send_word(input logic [WIDTH-1:0] d, input int gap);
      bit ok = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      s_valid = 1'b1;
      s_data  = d;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (s_ready) ok = 1'b1;
         tick();
      end
      s_valid = 1'b0;
      if (!ok) check("accept_timeout", 64'(ok), 64'd1);
   endtask

   task automatic fetch(input int adr, output logic [WIDTH-1:0] d);
      fetch_adrs = AW'(adr);
      tick();
      d = fetch_data;
   endtask

   task automatic model_write(input int adr, input logic [WIDTH-1:0] d);
      mem_model[adr % DEPTH] = d;
      written[adr % DEPTH]   = 1'b1;
   endtask

   // Loads words_q at base; with checksum enabled a trailer follows, deliberately
   // off by one when bad_trailer is set.
   task automatic run_load(input int base, input bit bad_trailer, input int maxgap, input string tag);
      logic [WIDTH-1:0] sum = '0;
      bit exp_err;
      start_load(base, words_q.size());
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      foreach (words_q[i]) begin
         send_word(words_q[i], $urandom_range(0, maxgap));
         model_write(base + i, words_q[i]);
         sum = sum + words_q[i];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(bad_trailer ? sum + 1 : sum, $urandom_range(0, maxgap));
      exp_err = bad_trailer;
`else
      unused_flag = bad_trailer;
      exp_err = 1'b0;
`endif
      check({tag, "_cpu_en"}, 64'(cpu_en), 64'(!exp_err));
      check({tag, "_error"},  64'(error),  64'(exp_err));
      check({tag, "_busy"},   64'(busy),   64'd0);
   endtask

   task automatic verify_mem(input string tag);
      logic [WIDTH-1:0] d;
      for (int a = 0; a < DEPTH; a++) begin
         if (written[a]) begin
            fetch(a, d);
            check($sformatf("%s_mem%0d", tag, a), 64'(d), 64'(mem_model[a]));
         end
      end
   endtask

   typedef struct {
      int len;
      bit exp_busy;
      bit exp_err;
   } len_vec_t;

   initial begin
      len_vec_t         len_tab [5];
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] fixed [4];

      len_tab[0] = '{0,         1'b0, 1'b1};
      len_tab[1] = '{1,         1'b1, 1'b0};
      len_tab[2] = '{DEPTH,     1'b1, 1'b0};
      len_tab[3] = '{DEPTH + 1, 1'b0, 1'b1};
      len_tab[4] = '{2*DEPTH-1, 1'b0, 1'b1};
      fixed[0] = 32'hE000_0007;
      fixed[1] = 32'hC1FF_E003;
      fixed[2] = 32'h1234_5678;
      fixed[3] = 32'h8018_0001;
      unused_flag = 1'b0;

      reset = 1'b1; load_req = 1'b0; load_base = '0; load_len = '0;
      halt = 1'b0; s_valid = 1'b0; s_data = '0; fetch_adrs = '0;
      for (int a = 0; a < DEPTH; a++) begin
         written[a] = 1'b0;
         mem_model[a] = '0;
      end
      tick(); tick();
      check_idle("reset", 1'b0);
      check("reset_fetch_data", 64'(fetch_data), 64'd0);
      reset = 1'b0;
      tick();

      // Basic load base=1 len=4
      words_q = {};
      foreach (fixed[i]) words_q.push_back(fixed[i]);
      run_load(1, 1'b0, 0, "basic");
      for (int i = 0; i < 4; i++) begin
         fetch(1 + i, d);
         check($sformatf("basic_fetch%0d", 1 + i), 64'(d), 64'(fixed[i]));
      end

      // Wrap: base DEPTH-2, len 4 -> DEPTH-2, DEPTH-1, 0, 1
      words_q = {32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
      run_load(DEPTH - 2, 1'b0, 1, "wrap");
      fetch(DEPTH - 1, d); check("wrap_top", 64'(d), 64'hA000_0002);
      fetch(0, d);         check("wrap_0",   64'(d), 64'hA000_0003);
      fetch(1, d);         check("wrap_1",   64'(d), 64'hA000_0004);

      // Length validation table; halt afterwards returns to IDLE holding error.
      foreach (len_tab[i]) begin
         start_load(3, len_tab[i].len);
         check($sformatf("len%0d_busy", i),    64'(busy),    64'(len_tab[i].exp_busy));
         check($sformatf("len%0d_s_ready", i), 64'(s_ready), 64'(len_tab[i].exp_busy));
         check($sformatf("len%0d_error", i),   64'(error),   64'(len_tab[i].exp_err));
         check($sformatf("len%0d_cpu_en", i),  64'(cpu_en),  64'd0);
         tick();
         check($sformatf("len%0d_s_ready2", i), 64'(s_ready), 64'(len_tab[i].exp_busy));
         halt = 1'b1; tick(); halt = 1'b0;
         check_idle($sformatf("len%0d_halt", i), len_tab[i].exp_err);
      end

      // Checksum-style sequence: 1,2,3 (+6 good / +7 bad when enabled)
      words_q = {32'd1, 32'd2, 32'd3};
      run_load(4, 1'b0, 0, "ck_good");
      run_load(4, 1'b1, 0, "ck_bad");

      // Halt after 2 of 4 words with gaps
      start_load(5, 4);
      send_word(32'h5555_0001, 2); model_write(5, 32'h5555_0001);
      send_word(32'h5555_0002, 1); model_write(6, 32'h5555_0002);
      halt = 1'b1; tick(); halt = 1'b0;
      check_idle("halt", 1'b0);
      fetch(5, d); check("halt_w0", 64'(d), 64'h5555_0001);
      fetch(6, d); check("halt_w1", 64'(d), 64'h5555_0002);

      // Reset mid-load, then a clean reload
      start_load(9, 3);
      send_word(32'h9999_0000, 0); model_write(9, 32'h9999_0000);
      reset = 1'b1; tick();
      check_idle("midrst", 1'b0);
      check("midrst_fetch_data", 64'(fetch_data), 64'd0);
      reset = 1'b0; tick();
      check_idle("postrst", 1'b0);
      fetch(9, d); check("midrst_partial", 64'(d), 64'h9999_0000);
      words_q = {32'h9999_1111, 32'h9999_2222, 32'h9999_3333};
      run_load(9, 1'b0, 1, "reload");
      verify_mem("reload");

      // Same-address read during write returns old data, new data next cycle
      start_load(12, 1);
      fetch_adrs = AW'(12);
      s_valid = 1'b1; s_data = 32'hBEEF_0012;
      tick();
      s_valid = 1'b0;
      check("rw_old", 64'(fetch_data), 64'(mem_model[12]));
      tick();
      check("rw_new", 64'(fetch_data), 64'hBEEF_0012);
      model_write(12, 32'hBEEF_0012);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(32'hBEEF_0012, 0);
`endif
      check("rw_cpu_en", 64'(cpu_en), 64'd1);

      // Randomized loads against the array model
      for (int r = 0; r < 20; r++) begin
         int base = $urandom_range(0, DEPTH - 1);
         int len  = $urandom_range(1, DEPTH);
         bit bad  = ($urandom_range(0, 3) == 0);
         words_q = {};
         for (int i = 0; i < len; i++) words_q.push_back($urandom);
         run_load(base, bad, 2, $sformatf("rnd%0d", r));
      end
      verify_mem("rnd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_prog_loader
`default_nettype wire
